// File: rtl/id_ex_pipe_reg.sv
// Decode-to-execute pipeline register: valid/ready handshake with a two-slot
// (MAIN + SKID) buffer, synchronous flush and side-effect gating on invalid.
//
// state   | meaning
// EMPTY   | no entry held, in_ready=1
// FULL    | MAIN holds the head entry, in_ready=1
// SKID    | MAIN and SKID both hold entries, in_ready=0
module id_ex_pipe_reg #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [4:0]      in_rs1_addr,
  input  logic [4:0]      in_rs2_addr,
  input  logic [4:0]      in_rd_addr,
  input  logic [3:0]      in_alu_op,
  input  logic            in_alu_src,
  input  logic [4:0]      in_ctrl,
  input  logic            in_reg_write,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1_addr,
  output logic [4:0]      out_rs2_addr,
  output logic [4:0]      out_rd_addr,
  output logic [3:0]      out_alu_op,
  output logic            out_alu_src,
  output logic [4:0]      out_ctrl,
  output logic            out_reg_write,
  output logic [1:0]      occupancy
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_SKID  = 2'd2
  } state_t;

  localparam int PW = 4*XLEN + 26;

  state_t          state;
  state_t          state_nx;
  logic [PW-1:0]   in_pl;
  logic [PW-1:0]   main_q;
  logic [PW-1:0]   skid_q;
  logic [4:0]      main_ctrl;
  logic            main_reg_write;
  logic            accept;
  logic            consume;

  assign in_pl = {in_pc, in_rs1_data, in_rs2_data, in_imm,
                  in_rs1_addr, in_rs2_addr, in_rd_addr,
                  in_alu_op, in_alu_src, in_ctrl, in_reg_write};

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: if (accept) state_nx = S_FULL;
        S_FULL: begin
          if (accept && !consume)      state_nx = S_SKID;
          else if (!accept && consume) state_nx = S_EMPTY;
        end
        S_SKID:  if (consume) state_nx = S_FULL;
        default: state_nx = S_EMPTY;
      endcase
    end
  end

  // Handshake outputs are registered from the next state so in_ready never
  // depends combinationally on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      occupancy <= 2'd0;
      main_q    <= '0;
      skid_q    <= '0;
    end else begin
      state     <= state_nx;
      in_ready  <= (state_nx != S_SKID);
      out_valid <= (state_nx != S_EMPTY);
      occupancy <= (state_nx == S_SKID) ? 2'd2 :
                   (state_nx == S_FULL) ? 2'd1 : 2'd0;
      if (!flush) begin
        case (state)
          S_EMPTY: if (accept) main_q <= in_pl;
          S_FULL: begin
            if (accept && consume) main_q <= in_pl;
            else if (accept)       skid_q <= in_pl;
          end
          S_SKID:  if (consume) main_q <= skid_q;
          default: ;
        endcase
      end
    end
  end

  assign {out_pc, out_rs1_data, out_rs2_data, out_imm,
          out_rs1_addr, out_rs2_addr, out_rd_addr,
          out_alu_op, out_alu_src, main_ctrl, main_reg_write} = main_q;

  // Stale entries must never trigger memory, branch or writeback side effects.
  assign out_ctrl      = main_ctrl & {5{out_valid}};
  assign out_reg_write = main_reg_write & out_valid;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Randomized and directed bench for id_ex_pipe_reg, checked against a queue
// model of the held instructions.
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [4:0]  rda;
    logic [3:0]  op;
    logic        src;
    logic [4:0]  ctrl;
    logic        rw;
  } pl_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  occupancy;
  pl_t         drv = '0;
  pl_t         obs;

  logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr, in_ctrl;
  logic [3:0]  in_alu_op;
  logic        in_alu_src, in_reg_write;
  logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [4:0]  out_rs1_addr, out_rs2_addr, out_rd_addr, out_ctrl;
  logic [3:0]  out_alu_op;
  logic        out_alu_src, out_reg_write;

  assign {in_pc, in_rs1_data, in_rs2_data, in_imm, in_rs1_addr, in_rs2_addr,
          in_rd_addr, in_alu_op, in_alu_src, in_ctrl, in_reg_write} = drv;
  assign obs = {out_pc, out_rs1_data, out_rs2_data, out_imm, out_rs1_addr,
                out_rs2_addr, out_rd_addr, out_alu_op, out_alu_src, out_ctrl,
                out_reg_write};

  id_ex_pipe_reg #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rd_addr(in_rd_addr), .in_alu_op(in_alu_op), .in_alu_src(in_alu_src),
    .in_ctrl(in_ctrl), .in_reg_write(in_reg_write),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_imm(out_imm), .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr),
    .out_rd_addr(out_rd_addr), .out_alu_op(out_alu_op), .out_alu_src(out_alu_src),
    .out_ctrl(out_ctrl), .out_reg_write(out_reg_write),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_pass = 0;
  pl_t  model_q[$];
  int   max_occ = 0;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic pl_t rnd_pl(input logic [31:0] pc);
    pl_t p;
    p.pc   = pc;
    p.rs1  = $urandom;
    p.rs2  = $urandom;
    p.imm  = $urandom;
    p.rs1a = 5'($urandom);
    p.rs2a = 5'($urandom);
    p.rda  = 5'($urandom);
    p.op   = 4'($urandom);
    p.src  = 1'($urandom);
    p.ctrl = 5'($urandom);
    p.rw   = 1'($urandom);
    return p;
  endfunction

  // One cycle: check outputs against the model, drive inputs, advance the model.
  task automatic step(input logic v, input logic rdy, input logic fl,
                      input pl_t p, output logic acc);
    logic con;
    @(negedge clk);
    chk("out_valid", 160'(out_valid), 160'(model_q.size() != 0));
    chk("in_ready", 160'(in_ready), 160'(model_q.size() < 2));
    chk("occupancy", 160'(occupancy), 160'(model_q.size()));
    if (model_q.size() != 0) chk("payload", 160'(obs), 160'(model_q[0]));
    else chk("ctrl_gate", 160'({out_ctrl, out_reg_write}), 160'(0));
    if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
    in_valid  = v;
    out_ready = rdy;
    flush     = fl;
    drv       = p;
    acc = v && (model_q.size() < 2) && !fl;
    con = rdy && (model_q.size() != 0);
    if (fl) model_q.delete();
    else begin
      if (con) void'(model_q.pop_front());
      if (acc) model_q.push_back(p);
    end
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, '0, a);
  endtask

  initial begin
    logic a;
    pl_t  p;
    int   idx;

    // reset and first accept
    @(negedge clk);
    chk("rst_out_valid", 160'(out_valid), 160'(0));
    chk("rst_in_ready", 160'(in_ready), 160'(1));
    chk("rst_occupancy", 160'(occupancy), 160'(0));
    chk("rst_payload", 160'(obs), 160'(0));
    rst_n = 1'b1;
    p = rnd_pl(32'h100);
    p.imm = 32'h14;
    p.src = 1'b1;
    step(1'b1, 1'b0, 1'b0, p, a);
    @(posedge clk); #1;
    chk("first_valid", 160'(out_valid), 160'(1));
    chk("first_pc", 160'(out_pc), 160'(32'h100));
    chk("first_imm", 160'(out_imm), 160'(32'h14));
    chk("first_alu_src", 160'(out_alu_src), 160'(1));
    idle(2);

    // streaming 8 with out_ready held high
    max_occ = 0;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, rnd_pl(32'(i*4)), a);
    idle(2);
    chk("stream_max_occ", 160'(max_occ), 160'(1));

    // back-pressure: out_ready low for 3 cycles mid-stream
    max_occ = 0;
    idx = 0;
    p = rnd_pl(32'h300);
    for (int c = 0; c < 14 && idx < 10; c++) begin
      step(1'b1, !(c >= 3 && c < 6), 1'b0, p, a);
      if (a) begin idx++; p = rnd_pl(32'h300 + 32'(idx*4)); end
    end
    idle(4);
    chk("bp_max_occ", 160'(max_occ), 160'(2));
    chk("bp_all_accepted", 160'(idx), 160'(10));

    // flush in SKID with pc 0x40 at head and 0x48 presented
    step(1'b1, 1'b0, 1'b0, rnd_pl(32'h40), a);
    step(1'b1, 1'b0, 1'b0, rnd_pl(32'h44), a);
    p = rnd_pl(32'h48);
    p.ctrl = 5'h1f;
    p.rw = 1'b1;
    step(1'b1, 1'b0, 1'b1, p, a);
    @(posedge clk); #1;
    chk("flush_out_valid", 160'(out_valid), 160'(0));
    chk("flush_occupancy", 160'(occupancy), 160'(0));
    chk("flush_gate", 160'({out_ctrl, out_reg_write}), 160'(0));
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, '0, a);
      chk("flush_no_48", 160'(out_valid && out_pc == 32'h48), 160'(0));
    end

    // asynchronous reset with two entries held
    step(1'b1, 1'b0, 1'b0, rnd_pl(32'h500), a);
    step(1'b1, 1'b0, 1'b0, rnd_pl(32'h504), a);
    step(1'b0, 1'b0, 1'b0, '0, a);
    chk("pre_rst_occ", 160'(occupancy), 160'(2));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 160'(out_valid), 160'(0));
    chk("arst_in_ready", 160'(in_ready), 160'(1));
    chk("arst_occupancy", 160'(occupancy), 160'(0));
    chk("arst_payload", 160'(obs), 160'(0));
    model_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // simultaneous accept and consume in FULL
    step(1'b1, 1'b0, 1'b0, rnd_pl(32'h200), a);
    step(1'b1, 1'b1, 1'b0, rnd_pl(32'h204), a);
    @(posedge clk); #1;
    chk("ac_occupancy", 160'(occupancy), 160'(1));
    chk("ac_pc", 160'(out_pc), 160'(32'h204));
    idle(2);

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 39) == 0), rnd_pl($urandom), a);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
